seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider that produces one quotient bit per clock. It is the inverse-direction companion to the team's ripple adders: the same carry-chain arithmetic, used as a subtractor (a + ~b + 1). It sits in the digit-detection datapath for normalisation and averaging steps. Operands arrive on a valid/ready input handshake, and results leave on a valid/ready output handshake.

---
 rtl/seq_divider.sv | 167 ++++++++++++++++
 tb/tb_seq_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, subtract on a ripple carry chain.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // in_ready and out_valid depend only on registered state.
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   p_shift, sub_b;
   logic [WIDTH-1:0] t_sum, p_next, q_next;
   logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
   logic             carry, t_cout;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;
`endif

   // P' - {0,divisor} as P' + ~{0,divisor} + 1; the top sum bit is never kept because a
   // restored remainder is always below the divisor.
   always_comb begin
      p_shift = {p_q, q_q[WIDTH-1]};
      sub_b   = ~{1'b0, dvs_q};
      carry   = 1'b1;
      t_sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         t_sum[i] = p_shift[i] ^ sub_b[i] ^ carry;
         carry    = (p_shift[i] & sub_b[i]) | (carry & (p_shift[i] ^ sub_b[i]));
      end
      t_cout = (p_shift[WIDTH] & sub_b[WIDTH]) | (carry & (p_shift[WIDTH] ^ sub_b[WIDTH]));
      p_next = t_cout ? t_sum : p_shift[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], t_cout};
   end

   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      a_mag = dividend[WIDTH-1] ? -dividend : dividend;
      b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
      q_fin = q_neg_q ? -q_next : q_next;
      r_fin = r_neg_q ? -p_next : p_next;
`else
      a_mag = dividend;
      b_mag = divisor;
      q_fin = q_next;
      r_fin = p_next;
`endif
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvs_d   = b_mag;
               q_d     = a_mag;
               p_d     = '0;
               count_d = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
               q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               r_neg_d = dividend[WIDTH-1];
`endif
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            p_d     = p_next;
            q_d     = q_next;
            count_d = count_q - 1'b1;
            if (count_q == '0) begin
               state_d = DONE;
               quot_d  = q_fin;
               rem_d   = r_fin;
               dbz_d   = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         p_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): vector table, backpressure, mid-operation reset.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic [1:0]   dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [2*W:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   vec_t vecs[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation and follow it through to handoff. exp_lat counts rising edges after
   // the accept edge until out_valid is seen high.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                         input int exp_lat, input int stall, input bit poke);
      int           lat;
      int           waitc;
      bit           busy_ok;
      logic [2*W:0] exp;
      exp_q.push_back({eq, er, ed});
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("in_ready_before_op", 32'(in_ready), 32'd1);
      out_ready = (stall == 0);
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = W'($urandom_range(0, 255));
      divisor  = W'($urandom_range(0, 255));
      lat      = 0;
      busy_ok  = 1'b1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         if (poke && lat == 3) begin
            in_valid = 1'b1;
            dividend = 8'd9;
            divisor  = 8'd2;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("in_ready_low_calc", 32'(busy_ok), 32'd1);
      check("in_ready_low_done", 32'(in_ready), 32'd0);
      exp = exp_q.pop_front();
      for (int s = 0; s < stall; s++) begin
         check("held_out_valid", 32'(out_valid), 32'd1);
         check("held_quotient", 32'(quotient), 32'(exp[2*W:W+1]));
         check("held_remainder", 32'(remainder), 32'(exp[W:1]));
         @(negedge clk);
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("quotient", 32'(quotient), 32'(exp[2*W:W+1]));
      check("remainder", 32'(remainder), 32'(exp[W:1]));
      check("div_by_zero", 32'(div_by_zero), 32'(exp[0]));
      out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_after_handoff", 32'(out_valid), 32'd0);
      check("in_ready_after_handoff", 32'(in_ready), 32'd1);
      check("quotient_kept_idle", 32'(quotient), 32'(exp[2*W:W+1]));
   endtask

   initial begin
      bit no_result;

      vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,  1'b0});
      vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
      vecs.push_back('{8'd3,   8'd200, 8'd0,   8'd3,  1'b0});
      vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
      vecs.push_back('{8'd0,   8'd9,   8'd0,   8'd0,  1'b0});
      vecs.push_back('{8'd55,  8'd0,   8'hFF,  8'd55, 1'b1});
      vecs.push_back('{8'd50,  8'd5,   8'd10,  8'd0,  1'b0});
`ifdef SEQ_DIVIDER_SIGNED_EN
      vecs.push_back('{8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0});
      vecs.push_back('{8'd100, 8'hF9,  8'hF2,  8'd2,  1'b0});
      vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'd0,  1'b0});
      vecs.push_back('{8'hFB,  8'd0,   8'hFF,  8'hFB, 1'b1});
`else
      vecs.push_back('{8'd200, 8'd3,   8'd66,  8'd2,  1'b0});
`endif

      #2;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
                vecs[i].dbz ? 0 : W, 0, 1'b0);
      end

      // backpressure with a stray in_valid pulse during CALC
`ifdef SEQ_DIVIDER_SIGNED_EN
      run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W, 5, 1'b1);
`else
      run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, W, 5, 1'b1);
`endif

      // asynchronous reset three cycles into CALC
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      no_result = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) no_result = 1'b0;
      end
      check("abort_no_result", 32'(no_result), 32'd1);
      run_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, W, 0, 1'b0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
